// File: rtl/scan_pkg.sv
// Shared types and helpers for the digit-scan sequencer feeding the 3-to-8 decoder.
package scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  // Decoder enable pair {G1,G2}
  localparam logic [1:0] ENA_ON  = 2'b10;
  localparam logic [1:0] ENA_OFF = 2'b01;

  // Lowest set bit of the mask; 0 when the mask is empty.
  function automatic logic [2:0] first_set(input logic [7:0] mask);
    logic [2:0] r_pos;
    r_pos = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) r_pos = 3'(i);
    end
    return r_pos;
  endfunction

  function automatic logic [3:0] nibble_at(input logic [31:0] digits, input logic [2:0] sel);
    return digits[{sel, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/scan_next_sel.sv
// Circular search for the next enabled position strictly after the current one.
module scan_next_sel
  import scan_pkg::*;
(
  input  logic [2:0] i_sel,
  input  logic [7:0] i_mask,
  output logic [2:0] o_sel,
  output logic       o_wrap
);

  logic [2:0] w_cand [1:7];
  logic [7:1] w_hit;

  genvar gi;
  generate
    for (gi = 1; gi < 8; gi++) begin : g_cand
      assign w_cand[gi] = i_sel + 3'(gi);
      assign w_hit[gi]  = i_mask[w_cand[gi]];
    end
  endgenerate

  // Farthest candidate first so the nearest hit wins; falls back to the
  // current position, which covers the single-active-bit case.
  always_comb begin
    o_sel = i_sel;
    for (int i = 7; i >= 1; i--) begin
      if (w_hit[i]) o_sel = w_cand[i];
    end
  end

  assign o_wrap = (o_sel <= i_sel);

endmodule

// File: rtl/scan_ctrl.sv
// Time-multiplexing sequencer: drives decoder select/enable with a per-slot
// dead-time and presents the selected digit nibble alongside.
module scan_ctrl
  import scan_pkg::*;
#(
  parameter int DIV   = 100000,
  parameter int BLANK = 4,
  parameter int CNT_W = 17
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iRun,
  input  logic [7:0]  iMask,
  input  logic [31:0] iDigits,
  output logic [2:0]  oSel,
  output logic [1:0]  oEna,
  output logic [3:0]  oNibble,
  output logic        oFrame
);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
  localparam bit               NO_BLANK   = (BLANK == 0);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_sel;
  logic [1:0]       r_ena;
  logic [3:0]       r_nibble;
  logic             r_frame;

  logic [2:0] w_first_sel;
  logic [2:0] w_next_sel;
  logic       w_wrap;
  logic       w_mask_any;
  logic [3:0] w_nib_cur;
  logic [3:0] w_nib_first;
  logic [3:0] w_nib_next;

  scan_next_sel u_next_sel (
    .i_sel  (r_sel),
    .i_mask (iMask),
    .o_sel  (w_next_sel),
    .o_wrap (w_wrap)
  );

  assign w_first_sel = first_set(iMask);
  assign w_mask_any  = |iMask;
  assign w_nib_cur   = nibble_at(iDigits, r_sel);
  assign w_nib_first = nibble_at(iDigits, w_first_sel);
  assign w_nib_next  = nibble_at(iDigits, w_next_sel);

  // Nibble is loaded from the select value being registered in the same edge,
  // so it lines up with oEna without an extra pipeline stage.
  always_ff @(posedge iClk) begin
    if (!iRst_n || !iRun) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_sel    <= 3'd0;
      r_ena    <= ENA_OFF;
      r_nibble <= 4'd0;
      r_frame  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_frame <= 1'b0;
          if (w_mask_any) begin
            r_cnt <= '0;
            r_sel <= w_first_sel;
            if (NO_BLANK) begin
              r_state  <= ST_SHOW;
              r_ena    <= ENA_ON;
              r_nibble <= w_nib_first;
            end else begin
              r_state  <= ST_BLANK;
              r_ena    <= ENA_OFF;
              r_nibble <= 4'd0;
            end
          end
        end

        ST_BLANK: begin
          r_frame <= 1'b0;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == BLANK_LAST) begin
            r_state  <= ST_SHOW;
            r_ena    <= ENA_ON;
            r_nibble <= w_nib_cur;
          end else begin
            r_ena    <= ENA_OFF;
            r_nibble <= 4'd0;
          end
        end

        ST_SHOW: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            if (!w_mask_any) begin
              r_state  <= ST_IDLE;
              r_sel    <= 3'd0;
              r_ena    <= ENA_OFF;
              r_nibble <= 4'd0;
              r_frame  <= 1'b0;
            end else begin
              r_sel   <= w_next_sel;
              r_frame <= w_wrap;
              if (NO_BLANK) begin
                r_state  <= ST_SHOW;
                r_ena    <= ENA_ON;
                r_nibble <= w_nib_next;
              end else begin
                r_state  <= ST_BLANK;
                r_ena    <= ENA_OFF;
                r_nibble <= 4'd0;
              end
            end
          end else begin
            r_cnt    <= r_cnt + 1'b1;
            r_frame  <= 1'b0;
            r_ena    <= ENA_ON;
            r_nibble <= w_nib_cur;
          end
        end

        default: begin
          r_state  <= ST_IDLE;
          r_cnt    <= '0;
          r_sel    <= 3'd0;
          r_ena    <= ENA_OFF;
          r_nibble <= 4'd0;
          r_frame  <= 1'b0;
        end
      endcase
    end
  end

  assign oSel    = r_sel;
  assign oEna    = r_ena;
  assign oNibble = r_nibble;
  assign oFrame  = r_frame;

endmodule

// File: tb/tb_scan_ctrl.sv
// Directed bench for scan_ctrl: one DIV=4/BLANK=1 instance and one DIV=2/BLANK=0 instance.
module tb_scan_ctrl;

  logic        clk;
  logic        rst_a_n;
  logic        rst_b_n;
  logic        run;
  logic [7:0]  mask;
  logic [31:0] digits;

  logic [2:0] a_sel;
  logic [1:0] a_ena;
  logic [3:0] a_nib;
  logic       a_frame;
  logic [2:0] b_sel;
  logic [1:0] b_ena;
  logic [3:0] b_nib;
  logic       b_frame;

  int checks = 0;
  int errors = 0;

  scan_ctrl #(.DIV(4), .BLANK(1), .CNT_W(2)) dut_a (
    .iClk    (clk),
    .iRst_n  (rst_a_n),
    .iRun    (run),
    .iMask   (mask),
    .iDigits (digits),
    .oSel    (a_sel),
    .oEna    (a_ena),
    .oNibble (a_nib),
    .oFrame  (a_frame)
  );

  scan_ctrl #(.DIV(2), .BLANK(0), .CNT_W(1)) dut_b (
    .iClk    (clk),
    .iRst_n  (rst_b_n),
    .iRun    (run),
    .iMask   (mask),
    .iDigits (digits),
    .oSel    (b_sel),
    .oEna    (b_ena),
    .oNibble (b_nib),
    .oFrame  (b_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic [2:0] sel, input logic [1:0] ena,
                         input logic [3:0] nib, input logic frame);
    check({tag, ".sel"}, a_sel, sel);
    check({tag, ".ena"}, a_ena, ena);
    check({tag, ".nib"}, a_nib, nib);
    check({tag, ".frame"}, a_frame, frame);
    $display("%s: sel=%0d ena=%b nib=%0h frame=%b", tag, a_sel, a_ena, a_nib, a_frame);
  endtask

  // One DIV=4/BLANK=1 slot: one blank cycle then three display cycles.
  // With digits 76543210 the displayed nibble equals the position.
  task automatic slot_a(input string tag, input logic [2:0] sel, input logic frame);
    step();
    check_a({tag, ".blank"}, sel, 2'b01, 4'd0, frame);
    for (int c = 1; c < 4; c++) begin
      step();
      check_a({tag, ".show"}, sel, 2'b10, 4'(sel), 1'b0);
    end
  endtask

  initial begin
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    run     = 1'b1;
    mask    = 8'hFF;
    digits  = 32'h7654_3210;

    // 1. Reset held for three clocks while running with a full mask
    for (int i = 0; i < 3; i++) begin
      step();
      check_a("reset", 3'd0, 2'b01, 4'd0, 1'b0);
    end
    rst_a_n = 1'b1;

    // 2. Full scan 0..7 then back to 0, frame only on the wrap
    for (int s = 0; s < 9; s++) begin
      slot_a("full", 3'(s % 8), (s == 8));
    end

    // 3. Sparse mask, changed late in the slot; takes effect at slot end
    mask = 8'b1010_0100;
    slot_a("sparse2", 3'd2, 1'b0);
    slot_a("sparse5", 3'd5, 1'b0);
    slot_a("sparse7", 3'd7, 1'b0);
    slot_a("sparse2w", 3'd2, 1'b1);

    // 4. Single digit: entering 3 from 2 is not a wrap, then every slot wraps
    mask = 8'h08;
    slot_a("single_in", 3'd3, 1'b0);
    slot_a("single_a", 3'd3, 1'b1);
    slot_a("single_b", 3'd3, 1'b1);

    // 5a. Mask cleared during SHOW of digit 4: slot completes, then IDLE
    mask = 8'h10;
    step();
    check_a("d4.blank", 3'd4, 2'b01, 4'd0, 1'b0);
    step();
    check_a("d4.show1", 3'd4, 2'b10, 4'd4, 1'b0);
    mask = 8'h00;
    step();
    check_a("d4.show2", 3'd4, 2'b10, 4'd4, 1'b0);
    step();
    check_a("d4.show3", 3'd4, 2'b10, 4'd4, 1'b0);
    step();
    check_a("d4.idle", 3'd0, 2'b01, 4'd0, 1'b0);
    step();
    check_a("d4.idle2", 3'd0, 2'b01, 4'd0, 1'b0);

    // 5b. iRun dropped mid-slot of digit 5
    mask = 8'h20;
    step();
    check_a("d5.blank", 3'd5, 2'b01, 4'd0, 1'b0);
    step();
    check_a("d5.show", 3'd5, 2'b10, 4'd5, 1'b0);
    run = 1'b0;
    step();
    check_a("d5.stop", 3'd0, 2'b01, 4'd0, 1'b0);
    run = 1'b1;

    // 6a. Reset asserted during SHOW of digit 6
    mask = 8'h40;
    step();
    check_a("d6.blank", 3'd6, 2'b01, 4'd0, 1'b0);
    step();
    check_a("d6.show", 3'd6, 2'b10, 4'd6, 1'b0);
    rst_a_n = 1'b0;
    step();
    check_a("d6.reset", 3'd0, 2'b01, 4'd0, 1'b0);
    rst_a_n = 1'b1;

    // 6b. BLANK=0, DIV=2: always enabled, position changes every 2 clocks
    mask    = 8'hFF;
    rst_b_n = 1'b1;
    for (int k = 0; k < 18; k++) begin
      step();
      check("b.sel", b_sel, 32'((k / 2) % 8));
      check("b.ena", b_ena, 32'b10);
      check("b.nib", b_nib, 32'((k / 2) % 8));
      check("b.frame", b_frame, 32'(k == 16));
      $display("b%0d: sel=%0d ena=%b nib=%0h frame=%b", k, b_sel, b_ena, b_nib, b_frame);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_ctrl.md
Name: scan_ctrl

Overview:
Time-multiplexing sequencer that sits directly upstream of the 3-to-8 decoder. It generates the decoder's 3-bit select code and its G1/G2 enable pair, stepping through the enabled digit positions. A fixed dead-time is inserted at the start of every slot so the decoder outputs never overlap. The selected 4-bit digit value is presented alongside for the downstream segment stage.

Parameters:
DIV, 100000, clocks per digit slot; DIV >= 2.
BLANK, 4, clocks at the start of each slot with the decoder disabled; 0 <= BLANK < DIV.
CNT_W, 17, slot counter width; must satisfy 2^CNT_W >= DIV.

Ports:
iClk  input  1  clock; all logic on rising edge.
iRst_n  input  1  reset, synchronous, active-low.
iRun  input  1  1 = scanning enabled.
iMask  input  8  per-digit enable; bit k = 1 means position k is scanned.
iDigits  input  32  eight nibbles; nibble k is iDigits[4k+3:4k].
oSel  output  3  select code to the decoder iData (D2..D0).
oEna  output  2  decoder {G1,G2}; 2'b10 = enabled, 2'b01 = disabled.
oNibble  output  4  nibble of the currently displayed position; 0 when not displaying.
oFrame  output  1  one-cycle pulse when the scan wraps.

Behaviour:
- All outputs are registered.
- Reset (iRst_n=0 at a clock edge), regardless of state:
  - state = IDLE, counter = 0.
  - oSel = 3'd0, oEna = 2'b01, oNibble = 4'd0, oFrame = 0.
- States: IDLE, BLANK, SHOW. Slot counter cnt runs 0..DIV-1 across BLANK+SHOW.
- IDLE:
  - oEna = 01, oSel = 0.
  - If iRun=1 and iMask != 0: next cycle BLANK, cnt = 0, oSel = lowest set bit of iMask.
  - If BLANK=0: enter SHOW directly.
- BLANK:
  - oEna = 01, cnt increments.
  - When cnt reaches BLANK-1, next state is SHOW.
- SHOW:
  - oEna = 10, cnt increments.
  - At cnt = DIV-1 (slot end), the next cycle has cnt = 0, state = BLANK (SHOW if BLANK=0), and oSel = next set bit of iMask strictly after oSel, searched circularly 7 -> 0.
- Frame pulse: oFrame = 1 for exactly the cycle in which the new slot begins, if the new oSel <= the old oSel (wrap). A single active bit therefore pulses every slot.
- iMask is sampled only at slot end and on IDLE exit. Mid-slot mask changes do not truncate the current slot. If iMask = 0 at slot end: go to IDLE, no oFrame.
- iRun = 0 in any state: next cycle IDLE, cnt = 0, oSel = 0, oEna = 01, oNibble = 0, no oFrame.
- oNibble:
  - Equals the iDigits nibble at oSel in every cycle where oEna = 10.
  - Otherwise 0.
  - Computed from next-state sel so it is aligned with oEna; there is no extra latency.
  - It tracks iDigits changes with 1-cycle latency.
- Slot length is exactly DIV clocks. Display-on time is DIV-BLANK clocks per slot.
- cnt never exceeds DIV-1; there is no counter overflow path.

Decomposition:
- Package scan_pkg:
  - state encoding (IDLE=2'd0, BLANK=2'd1, SHOW=2'd2).
  - ENA_ON = 2'b10, ENA_OFF = 2'b01.
  - function first_set(mask).
- One combinational sub-module, scan_next_sel: inputs current sel[2:0] and mask[7:0]; outputs next sel[2:0] (circular search after current) and wrap flag. It is instantiated once in scan_ctrl.

Test Plan:
1. Reset behaviour: with iRst_n=0 for 3 clocks while iRun=1, iMask=FF → oSel=0, oEna=01, oNibble=0, oFrame=0 throughout. Deasserting reset then starts BLANK on the next clock.
2. Full scan: DIV=4, BLANK=1, iMask=FF, iDigits=32'h76543210, iRun=1 from reset release.
   - Each slot: 1 cycle oEna=01, then 3 cycles oEna=10 with oNibble=oSel.
   - oSel steps 0,1,…,7,0.
   - oFrame pulses once, at the cycle oSel returns to 0 (every 32 clocks).
3. Sparse mask: iMask=8'b1010_0100, same DIV/BLANK → oSel sequence 2,5,7,2. oFrame is asserted on the 7 → 2 transition only.
4. Single digit: iMask=8'h08 → oSel stays 3. oFrame pulses every 4 clocks. Every slot still has a 1-cycle blank.
5. Mid-slot events:
   - Clearing iMask to 00 during SHOW of digit 4 → slot completes, then IDLE with oEna=01 and no oFrame.
   - Dropping iRun mid-slot → IDLE on the next clock with oSel=0, oNibble=0.
6. Mid-operation reset and BLANK=0:
   - Asserting iRst_n=0 during SHOW of digit 6 → next clock all outputs at reset values.
   - With BLANK=0, DIV=2 → oEna stays 10 continuously and oSel changes every 2 clocks.
